// File: rtl/sample_readout_if.sv
// Command bus between the host and sample_readout.
//   addr        register address; [15:8] block position, [7:0] register
//   cs          chip select
//   rd / wr     read / write strobes
//   cmd_data_in write data
//   data_out    read data returned by the selected block
interface sample_readout_if;
  logic [15:0] addr;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] cmd_data_in;
  logic [31:0] data_out;

  modport master (output addr, cs, rd, wr, cmd_data_in, input data_out);
  modport slave  (input addr, cs, rd, wr, cmd_data_in, output data_out);
endinterface

// File: rtl/sample_readout.sv
// Host-side drain of the sample FIFO. One word is prefetched into a holding
// register and served on NEXT_SAMPLE; each completed host read of NEXT_SAMPLE
// consumes it and prefetches the next. Also a saturating consumed-sample
// counter, a status register and a flush (CLEAR) command.
//   clk, rst           clock, synchronous active-high reset
//   bus                command bus (slave side)
//   fifo_rd_en         pop request to the sample FIFO
//   fifo_dout          FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty         FIFO empty flag
//   fifo_almost_empty  FIFO almost-empty flag
//   sample_available   holding register holds a valid word
module sample_readout #(
  parameter logic [7:0] POSITION = 8'd243,
  parameter int         CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  sample_readout_if.slave        bus,
  output logic                   fifo_rd_en,
  input  logic [15:0]            fifo_dout,
  input  logic                   fifo_empty,
  input  logic                   fifo_almost_empty,
  output logic                   sample_available
);

  localparam logic [7:0]  REG_NEXT   = 8'd1;
  localparam logic [7:0]  REG_NUM    = 8'd2;
  localparam logic [7:0]  REG_CMD    = 8'd5;
  localparam logic [7:0]  REG_STATUS = 8'd6;
  localparam logic [31:0] CMD_CLEAR  = 32'd5;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL, S_FLUSH} state_t;

  state_t           state;
  logic [15:0]      holding;
  logic             holding_valid;
  logic [CNT_W-1:0] count;
  logic             rd_d, rd_dd;

  logic       sel, rd_done, clear, flushing;
  logic [7:0] reg_a;
  logic [31:0] rdata;

  assign reg_a    = bus.addr[7:0];
  assign sel      = bus.cs & (bus.addr[15:8] == POSITION);
  // Falling edge of the delayed NEXT_SAMPLE strobe: one event per host read,
  // however long the strobe is held.
  assign rd_done  = ~rd_d & rd_dd;
  assign clear    = sel & bus.wr & (reg_a == REG_CMD) & (bus.cmd_data_in == CMD_CLEAR);
  assign flushing = (state == S_FLUSH);

  // Combinational so a word appearing in the FIFO is popped the same cycle.
  assign fifo_rd_en       = ~rst & ~fifo_empty & ((state == S_EMPTY) | (state == S_FLUSH));
  assign sample_available = holding_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_EMPTY;
      holding       <= '0;
      holding_valid <= 1'b0;
      count         <= '0;
      rd_d          <= 1'b0;
      rd_dd         <= 1'b0;
    end else begin
      rd_d  <= bus.rd & sel & (reg_a == REG_NEXT);
      rd_dd <= rd_d;
      if (clear) begin
        // Wins over a same-cycle rd_done; a word landing from an earlier pop
        // is dropped because WAIT is abandoned here.
        holding       <= '0;
        holding_valid <= 1'b0;
        count         <= '0;
        state         <= S_FLUSH;
      end else begin
        case (state)
          S_EMPTY: if (fifo_rd_en) state <= S_WAIT;
          S_WAIT: begin
            holding       <= fifo_dout;
            holding_valid <= 1'b1;
            state         <= S_FULL;
          end
          S_FULL: if (rd_done) begin
            holding_valid <= 1'b0;
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            state         <= S_EMPTY;
          end
          S_FLUSH: if (fifo_empty) state <= S_EMPTY;
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_a)
      REG_NEXT:   rdata = {15'b0, holding_valid, holding & {16{holding_valid}}};
      REG_NUM:    rdata = 32'(count);
      REG_STATUS: rdata = {28'b0, holding_valid, fifo_almost_empty, fifo_empty, flushing};
      default:    rdata = '0;
    endcase
  end

  assign bus.data_out = (sel & bus.rd & ~rst) ? rdata : 32'd0;

endmodule

// File: tb/tb_sample_readout.sv
module tb_sample_readout;
  logic clk, rst;
  logic [15:0] addr;
  logic        cs1, cs2, rd, wr;
  logic [31:0] din;

  sample_readout_if b1 ();
  sample_readout_if b2 ();
  assign b1.addr = addr; assign b1.cs = cs1; assign b1.rd = rd;
  assign b1.wr = wr;     assign b1.cmd_data_in = din;
  assign b2.addr = addr; assign b2.cs = cs2; assign b2.rd = rd;
  assign b2.wr = wr;     assign b2.cmd_data_in = din;

  // DUT1: finite FIFO model
  logic        rd_en1, avail1, empty1, aempty1;
  logic [15:0] dout1;
  logic [15:0] mem [0:63];
  int          wp, rp, pops1, bad1;
  assign empty1  = (wp == rp);
  assign aempty1 = ((wp - rp) <= 1);

  sample_readout #(.POSITION(8'd243), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .fifo_rd_en(rd_en1), .fifo_dout(dout1),
    .fifo_empty(empty1), .fifo_almost_empty(aempty1), .sample_available(avail1));

  always @(posedge clk) begin
    if (rd_en1) begin
      if (wp == rp) bad1 <= bad1 + 1;
      else begin
        dout1 <= mem[rp[5:0]];
        rp    <= rp + 1;
        pops1 <= pops1 + 1;
      end
    end
  end

  // DUT2: CNT_W=4 with an endless source
  logic        rd_en2, avail2;
  logic [15:0] dout2, src2;
  sample_readout #(.POSITION(8'd243), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(b2), .fifo_rd_en(rd_en2), .fifo_dout(dout2),
    .fifo_empty(1'b0), .fifo_almost_empty(1'b0), .sample_available(avail2));

  always @(posedge clk) if (rd_en2) begin
    dout2 <= src2;
    src2  <= src2 + 16'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wp[5:0]] = v;
    wp = wp + 1;
  endtask

  // Sample data at the start of the strobe, hold rd for 'hold' cycles,
  // then leave time for completion and refill.
  task automatic bus_rd(input bit sel2, input logic [7:0] r, input int hold,
                        output logic [31:0] d);
    addr = {8'd243, r}; cs1 = ~sel2; cs2 = sel2; rd = 1'b1;
    #1 d = sel2 ? b2.data_out : b1.data_out;
    repeat (hold) tick();
    rd = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    repeat (6) tick();
  endtask

  task automatic bus_wr(input logic [7:0] r, input logic [31:0] v);
    addr = {8'd243, r}; cs1 = 1'b1; wr = 1'b1; din = v;
    tick();
    wr = 1'b0; cs1 = 1'b0; din = '0;
  endtask

  logic [31:0] d;
  int p0;

  initial begin
    wp = 0; rp = 0; pops1 = 0; bad1 = 0; dout1 = '0; dout2 = '0; src2 = 16'h0C00;
    rst = 1'b1; addr = '0; cs1 = 0; cs2 = 0; rd = 0; wr = 0; din = '0;
    repeat (3) tick();
    chk("rst_rd_en", 32'(rd_en1), 0);
    chk("rst_avail", 32'(avail1), 0);
    addr = {8'd243, 8'd6}; cs1 = 1'b1; rd = 1'b1;
    #1 chk("rst_dout", b1.data_out, 0);
    tick();
    rd = 0; cs1 = 0; rst = 1'b0;
    tick();
    bus_rd(0, 8'd2, 1, d); chk("rst_num", d, 0);
    bus_rd(0, 8'd6, 1, d); chk("rst_status", d, 32'h6);

    // T3: read with nothing available
    bus_rd(0, 8'd1, 1, d); chk("t3_next", d, 0);
    bus_rd(0, 8'd2, 1, d); chk("t3_num", d, 0);
    chk("t3_pops", pops1, 0);

    // T1: prefetch latency and two consumed words
    push(16'h2ABC); push(16'h4123);
    #1 chk("t1_rd_en", 32'(rd_en1), 1);
    tick(); chk("t1_avail_t1", 32'(avail1), 0);
    tick(); chk("t1_avail_t2", 32'(avail1), 1);
    bus_rd(0, 8'd1, 1, d); chk("t1_next0", d, 32'h00012ABC);
    bus_rd(0, 8'd1, 1, d); chk("t1_next1", d, 32'h00014123);
    bus_rd(0, 8'd2, 1, d); chk("t1_num", d, 2);
    chk("t1_pops", pops1, 2);

    bus_wr(8'd5, 32'd5);
    repeat (3) tick();
    bus_rd(0, 8'd2, 1, d); chk("clr_num", d, 0);

    // T2: long strobe pops exactly once
    p0 = pops1;
    push(16'h1111); push(16'h2222); push(16'h3333);
    repeat (4) tick();
    chk("t2_prefetch", pops1 - p0, 1);
    addr = {8'd243, 8'd1}; cs1 = 1'b1; rd = 1'b1;
    #1 chk("t2_next", b1.data_out, 32'h00011111);
    repeat (20) tick();
    chk("t2_pops_hold", pops1 - p0, 1);
    rd = 0; cs1 = 0;
    repeat (6) tick();
    chk("t2_pops_after", pops1 - p0, 2);
    bus_rd(0, 8'd2, 1, d); chk("t2_num", d, 1);
    bus_rd(0, 8'd6, 1, d); chk("t2_status", d, 32'hC);

    // T4: flush drains queued words
    bus_wr(8'd5, 32'd5);
    repeat (3) tick();
    p0 = pops1;
    for (int i = 0; i < 10; i++) push(16'hA000 + 16'(i));
    tick();
    bus_wr(8'd5, 32'd5);
    bus_rd(0, 8'd6, 1, d); chk("t4_flushing", d, 32'h1);
    repeat (12) tick();
    chk("t4_pops", pops1 - p0, 10);
    bus_rd(0, 8'd6, 1, d); chk("t4_status_done", d, 32'h6);
    bus_rd(0, 8'd2, 1, d); chk("t4_num", d, 0);
    chk("t4_avail", 32'(avail1), 0);

    // T4b: clear coincident with rd_done
    push(16'hB001); push(16'hB002);
    repeat (4) tick();
    bus_rd(0, 8'd1, 1, d); chk("t4b_next", d, 32'h0001B001);
    bus_rd(0, 8'd2, 1, d); chk("t4b_num1", d, 1);
    addr = {8'd243, 8'd1}; cs1 = 1'b1; rd = 1'b1;
    tick();
    rd = 0; cs1 = 0;
    tick();
    bus_wr(8'd5, 32'd5);
    repeat (3) tick();
    bus_rd(0, 8'd2, 1, d); chk("t4b_num0", d, 0);
    chk("t4b_avail", 32'(avail1), 0);

    // T6: reset during WAIT
    push(16'h6000); push(16'h6001); push(16'h6002);
    repeat (4) tick();
    addr = {8'd243, 8'd1}; cs1 = 1'b1; rd = 1'b1;
    tick();
    rd = 0; cs1 = 0;
    tick(); tick();
    chk("t6_pop", 32'(rd_en1), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_avail", 32'(avail1), 0);
    chk("t6_rst_rd_en", 32'(rd_en1), 0);
    rst = 1'b0;
    #1 chk("t6_refill", 32'(rd_en1), 1);
    tick(); tick();
    chk("t6_avail", 32'(avail1), 1);
    bus_rd(0, 8'd2, 1, d); chk("t6_num", d, 0);
    bus_rd(0, 8'd1, 1, d); chk("t6_next", d, 32'h00016002);

    // T5: saturation with CNT_W=4
    for (int i = 0; i < 20; i++) begin
      bus_rd(1, 8'd1, 1, d);
      if (i == 13) begin bus_rd(1, 8'd2, 1, d); chk("t5_num14", d, 14); end
    end
    bus_rd(1, 8'd2, 1, d); chk("t5_num_sat", d, 15);
    bus_rd(0, 8'd2, 1, d); chk("t5_dut1_num", d, 1);

    chk("no_pop_when_empty", bad1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
